// File: rtl/temporizador_multicanal.sv
// temporizador_multicanal
//   N-channel dispense sequencer. A start request latches the per-channel
//   durations into a shadow copy. Each channel's motor enable is then driven
//   in turn, lowest channel first, for D_k ticks. Channels with a zero
//   duration are skipped. A tick lasts TICK_DIV clock cycles.
//   Loop mode re-latches the durations and restarts without a gap. abort
//   drops everything on the next cycle.
// Ports
//   clk        system clock, posedge
//   rst        synchronous active-high reset
//   enter      start request (ignored while busy)
//   abort      stop immediately; cancels a pending loop restart
//   loop       restart automatically after the last channel
//   ciclos     packed durations, channel k at [k*CNT_W +: CNT_W]
//   ch_active  one-hot motor enable
//   flags      flags[k] high during the last active cycle of channel k
//   busy       sequence running
//   done       one-cycle pulse after each completed pass
//
// state  | meaning
// S_IDLE | waiting for enter; all enables off
// S_RUN  | one channel enabled, down-counting its duration
module temporizador_multicanal #(
  parameter int N_CH     = 3,
  parameter int CNT_W    = 5,
  parameter int TICK_DIV = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enter,
  input  logic                    abort,
  input  logic                    loop,
  input  logic [N_CH*CNT_W-1:0]   ciclos,
  output logic [N_CH-1:0]         ch_active,
  output logic [N_CH-1:0]         flags,
  output logic                    busy,
  output logic                    done
);

  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int PS_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PS_W-1:0] PS_TOP = PS_W'(TICK_DIV - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]            state_q, state_n;
  logic [CH_W-1:0]       ch_q, ch_n;
  logic [PS_W-1:0]       presc_q, presc_n;
  logic [CNT_W-1:0]      dur_q, dur_n;
  logic [N_CH*CNT_W-1:0] shadow_q, shadow_n;
  logic [N_CH-1:0]       act_n, flags_n;
  logic                  busy_n, done_n;

  logic                  last, launch;
  logic [N_CH*CNT_W-1:0] src;
  int                    from;
  logic [CH_W:0]         sel, nxt;

  // Lowest channel >= from with a non-zero duration; MSB of the result is "found".
  function automatic logic [CH_W:0] pick(input logic [N_CH*CNT_W-1:0] d, input int start);
    logic [CH_W:0] r;
    r = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (k >= start && d[k*CNT_W +: CNT_W] != '0) r = {1'b1, CH_W'(k)};
    end
    return r;
  endfunction

  assign last = (state_q == S_RUN) && (presc_q == '0) && (dur_q == CNT_W'(1));
  assign nxt  = pick(shadow_q, int'(ch_q) + 1);

  always_comb begin
    state_n  = state_q;
    ch_n     = ch_q;
    presc_n  = presc_q;
    dur_n    = dur_q;
    shadow_n = shadow_q;
    act_n    = ch_active;
    busy_n   = busy;
    done_n   = 1'b0;
    launch   = 1'b0;
    src      = shadow_q;
    from     = 0;

    case (state_q)
      S_IDLE: begin
        if (enter && !abort) begin
          shadow_n = ciclos;
          src      = ciclos;
          launch   = 1'b1;
        end
      end
      default: begin
        if (abort) begin
          state_n = S_IDLE;
          act_n   = '0;
          busy_n  = 1'b0;
        end else if (last) begin
          launch = 1'b1;
          if (!nxt[CH_W] && loop) begin
            // Pass complete: report it and restart from fresh durations in the same cycle.
            done_n   = 1'b1;
            shadow_n = ciclos;
            src      = ciclos;
          end else begin
            from = int'(ch_q) + 1;
          end
        end else if (presc_q == '0) begin
          presc_n = PS_TOP;
          dur_n   = dur_q - CNT_W'(1);
        end else begin
          presc_n = presc_q - PS_W'(1);
        end
      end
    endcase

    sel = pick(src, from);
    if (launch) begin
      if (sel[CH_W]) begin
        state_n = S_RUN;
        ch_n    = sel[CH_W-1:0];
        presc_n = PS_TOP;
        dur_n   = src[int'(sel[CH_W-1:0])*CNT_W +: CNT_W];
        act_n   = N_CH'(1) << sel[CH_W-1:0];
        busy_n  = 1'b1;
      end else begin
        // Nothing left (or nothing at all) to run: finish the pass.
        state_n = S_IDLE;
        act_n   = '0;
        busy_n  = 1'b0;
        done_n  = 1'b1;
      end
    end

    // Flag is registered, so it is decided from the counters of the coming cycle.
    flags_n = ((state_n == S_RUN) && (presc_n == '0) && (dur_n == CNT_W'(1))) ? act_n : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ch_q      <= '0;
      presc_q   <= '0;
      dur_q     <= '0;
      shadow_q  <= '0;
      ch_active <= '0;
      flags     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_n;
      ch_q      <= ch_n;
      presc_q   <= presc_n;
      dur_q     <= dur_n;
      shadow_q  <= shadow_n;
      ch_active <= act_n;
      flags     <= flags_n;
      busy      <= busy_n;
      done      <= done_n;
    end
  end

endmodule

// File: tb/tb_temporizador_multicanal.sv
// Directed bench for temporizador_multicanal. Two instances share stimulus:
// dut1 with TICK_DIV=1 and dut4 with TICK_DIV=4. Each cycle the bench compares
// the packed vector {ch_active, flags, busy, done} against a hand-written table.
module tb_temporizador_multicanal;

  logic        clk;
  logic        rst, enter, abort, loop;
  logic [14:0] ciclos;
  logic [2:0]  act1, flg1, act4, flg4;
  logic        busy1, done1, busy4, done4;

  int checks = 0;
  int errors = 0;

  temporizador_multicanal #(.N_CH(3), .CNT_W(5), .TICK_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .enter(enter), .abort(abort), .loop(loop), .ciclos(ciclos),
    .ch_active(act1), .flags(flg1), .busy(busy1), .done(done1));

  temporizador_multicanal #(.N_CH(3), .CNT_W(5), .TICK_DIV(4)) dut4 (
    .clk(clk), .rst(rst), .enter(enter), .abort(abort), .loop(loop), .ciclos(ciclos),
    .ch_active(act4), .flags(flg4), .busy(busy4), .done(done4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wire [7:0] obs1 = {act1, flg1, busy1, done1};
  wire [7:0] obs4 = {act4, flg4, busy4, done4};

  localparam logic [14:0] D_T1 = {5'd1, 5'd2, 5'd3};

  // {ch_active, flags, busy, done} for cycles 1..N after enter in cycle 0
  localparam logic [7:0] T1 [8] = '{8'b001_000_10, 8'b001_000_10, 8'b001_001_10, 8'b010_000_10,
                                    8'b010_010_10, 8'b100_100_10, 8'b000_000_01, 8'b000_000_00};
  localparam logic [7:0] T2 [8] = '{8'b001_000_10, 8'b001_001_10, 8'b100_000_10, 8'b100_000_10,
                                    8'b100_000_10, 8'b100_100_10, 8'b000_000_01, 8'b000_000_00};
  localparam logic [7:0] T3 [10] = '{8'b001_000_10, 8'b001_000_10, 8'b001_000_10, 8'b001_000_10,
                                     8'b001_000_10, 8'b001_000_10, 8'b001_000_10, 8'b001_001_10,
                                     8'b000_000_01, 8'b000_000_00};
  localparam logic [7:0] T5 [11] = '{8'b001_001_10, 8'b010_010_10, 8'b100_100_10, 8'b001_001_11,
                                     8'b010_010_10, 8'b100_100_10, 8'b001_001_11, 8'b010_010_10,
                                     8'b100_100_10, 8'b000_000_01, 8'b000_000_00};

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_rst();
    rst = 1'b1; enter = 1'b0; abort = 1'b0; loop = 1'b0;
    step();
    chk("rst_dut1", obs1, 8'h00);
    chk("rst_dut4", obs4, 8'h00);
    rst = 1'b0;
  endtask

  // Basic D={1,2,3} pass; with noise, enter is held and ciclos scrambled mid-run.
  task automatic run_t1(input string tag, input bit noise);
    ciclos = D_T1;
    enter  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("%s_c%0d", tag, i + 1), obs1, T1[i]);
      enter  = (noise && i >= 1 && i <= 4);
      ciclos = (noise && i >= 1 && i <= 4) ? {5'd7, 5'd7, 5'd7} : D_T1;
    end
  endtask

  initial begin
    rst = 1'b1; enter = 1'b0; abort = 1'b0; loop = 1'b0; ciclos = '0;
    step();
    do_rst();

    // sequential channels, no gaps
    run_t1("t1", 1'b0);

    // zero-duration middle channel skipped
    do_rst();
    ciclos = {5'd4, 5'd0, 5'd2};
    enter  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("t2_c%0d", i + 1), obs1, T2[i]);
      enter = 1'b0;
    end

    // prescaler: TICK_DIV=4, D0=2
    do_rst();
    ciclos = {5'd0, 5'd0, 5'd2};
    enter  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("t3_c%0d", i + 1), obs4, T3[i]);
      enter = 1'b0;
    end

    // abort in second cycle of ch1, then full restart
    do_rst();
    ciclos = D_T1;
    enter  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("t4_c%0d", i + 1), obs1, T1[i]);
      enter = 1'b0;
    end
    abort = 1'b1;
    step();
    chk("t4_abort", obs1, 8'h00);
    abort = 1'b0;
    step();
    chk("t4_nodone", obs1, 8'h00);
    run_t1("t4r", 1'b0);

    // loop mode, then drop loop
    do_rst();
    ciclos = {5'd1, 5'd1, 5'd1};
    loop   = 1'b1;
    enter  = 1'b1;
    for (int i = 0; i < 11; i++) begin
      step();
      chk($sformatf("t5_c%0d", i + 1), obs1, T5[i]);
      enter = 1'b0;
      if (i == 6) loop = 1'b0;
    end

    // enter and ciclos changes while busy are ignored
    do_rst();
    run_t1("t6n", 1'b1);

    // rst mid-run
    ciclos = D_T1;
    enter  = 1'b1;
    step();
    chk("t6r_c1", obs1, T1[0]);
    enter = 1'b0;
    step();
    chk("t6r_c2", obs1, T1[1]);
    rst = 1'b1;
    step();
    chk("t6r_rst", obs1, 8'h00);
    rst = 1'b0;
    step();
    chk("t6r_after", obs1, 8'h00);

    // all-zero durations: done next cycle, never busy
    ciclos = '0;
    enter  = 1'b1;
    step();
    chk("t6z_done", obs1, 8'b000_000_01);
    enter = 1'b0;
    step();
    chk("t6z_idle", obs1, 8'h00);

    // abort and enter together in IDLE: no start
    ciclos = D_T1;
    enter  = 1'b1;
    abort  = 1'b1;
    step();
    chk("t6a_c1", obs1, 8'h00);
    enter = 1'b0;
    abort = 1'b0;
    step();
    chk("t6a_c2", obs1, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
